// File: rtl/cell_select_ctrl_pkg.sv
// Shared types, constants and helpers for the 3x3 cell selection controller.
package cell_select_ctrl_pkg;

  localparam int unsigned GRID        = 3;
  localparam int unsigned CELLS       = GRID * GRID;
  localparam int unsigned IDX_W       = 4;
  localparam int unsigned NUM_LINES   = 8;
  localparam int unsigned NUM_BTNS    = 6;
  localparam logic [IDX_W-1:0] CURSOR_HOME = IDX_W'(4);

  typedef enum logic [1:0] {
    ST_PLAY  = 2'd0,
    ST_DONE  = 2'd1,
    ST_CLEAR = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    ACT_NONE  = 3'd0,
    ACT_CLR   = 3'd1,
    ACT_SEL   = 3'd2,
    ACT_UP    = 3'd3,
    ACT_DOWN  = 3'd4,
    ACT_LEFT  = 3'd5,
    ACT_RIGHT = 3'd6
  } action_e;

  // Rows, columns, then the two diagonals
  localparam logic [CELLS-1:0] WIN_LINES [NUM_LINES] = '{
    9'h007, 9'h038, 9'h1C0, 9'h049, 9'h092, 9'h124, 9'h111, 9'h054
  };

  function automatic logic [CELLS-1:0] onehot(input logic [IDX_W-1:0] idx);
    return CELLS'(1) << idx;
  endfunction

  function automatic logic has_line(input logic [CELLS-1:0] mask);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < int'(NUM_LINES); i++) begin
      if ((mask & WIN_LINES[i]) == WIN_LINES[i]) hit = 1'b1;
    end
    return hit;
  endfunction

  // Moves wrap within the current row or column
  function automatic logic [IDX_W-1:0] move_cursor(input logic [IDX_W-1:0] idx, input action_e act);
    logic [1:0] row;
    logic [1:0] col;
    row = 2'(idx / IDX_W'(GRID));
    col = 2'(idx % IDX_W'(GRID));
    case (act)
      ACT_UP:    row = (row == 2'd0) ? 2'd2 : row - 2'd1;
      ACT_DOWN:  row = (row == 2'd2) ? 2'd0 : row + 2'd1;
      ACT_LEFT:  col = (col == 2'd0) ? 2'd2 : col - 2'd1;
      ACT_RIGHT: col = (col == 2'd2) ? 2'd0 : col + 2'd1;
      default:   ;
    endcase
    return IDX_W'(row) * IDX_W'(GRID) + IDX_W'(col);
  endfunction

endpackage

// File: rtl/cell_select_ctrl_btn_edge.sv
// Rising-edge detector for one debounced button level.
module cell_select_ctrl_btn_edge (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic rise_c
);

  logic btn_q;

  always_ff @(posedge clk) begin
    if (reset) btn_q <= 1'b0;
    else       btn_q <= btn_i;
  end

  assign rise_c = btn_i & ~btn_q;

endmodule

// File: rtl/cell_select_ctrl.sv
// Cursor/mark controller for the 3x3 grid; cell and cursor masks are
// republished only on frame_start so the renderer never tears.
module cell_select_ctrl
  import cell_select_ctrl_pkg::*;
#(
  parameter int unsigned BLINK_FRAMES = 30
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             btn_up,
  input  logic             btn_down,
  input  logic             btn_left,
  input  logic             btn_right,
  input  logic             btn_sel,
  input  logic             btn_clr,
  input  logic             frame_start,
  output logic [CELLS-1:0] cell_mask,
  output logic [CELLS-1:0] cursor_mask,
  output logic [IDX_W-1:0] cursor_idx,
  output logic             game_over,
  output logic             win
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_FRAMES - 1);

  logic [NUM_BTNS-1:0] btn_lvl;
  logic [NUM_BTNS-1:0] ev_c;

  state_e           state_q,   state_d;
  logic [CELLS-1:0] pend_q,    pend_d;
  logic [CELLS-1:0] cell_q,    cell_d;
  logic [CELLS-1:0] curm_q,    curm_d;
  logic [IDX_W-1:0] cursor_q,  cursor_d;
  logic [CNT_W-1:0] blink_cnt_q, blink_cnt_d;
  logic             blink_on_q,  blink_on_d;
  logic             over_q,    over_d;
  logic             win_q,     win_d;

  action_e          act_c;
  logic [CELLS-1:0] sel_mask_c;

  // Bit order: clr, sel, up, down, left, right
  assign btn_lvl = {btn_clr, btn_sel, btn_up, btn_down, btn_left, btn_right};

  for (genvar g = 0; g < int'(NUM_BTNS); g++) begin : g_edge
    cell_select_ctrl_btn_edge u_edge (
      .clk    (clk),
      .reset  (reset),
      .btn_i  (btn_lvl[g]),
      .rise_c (ev_c[g])
    );
  end

  // One action per cycle; lower-priority events are dropped
  always_comb begin
    act_c = ACT_NONE;
    if      (ev_c[5]) act_c = ACT_CLR;
    else if (ev_c[4]) act_c = ACT_SEL;
    else if (ev_c[3]) act_c = ACT_UP;
    else if (ev_c[2]) act_c = ACT_DOWN;
    else if (ev_c[1]) act_c = ACT_LEFT;
    else if (ev_c[0]) act_c = ACT_RIGHT;
  end

  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    cell_d      = cell_q;
    curm_d      = curm_q;
    cursor_d    = cursor_q;
    blink_cnt_d = blink_cnt_q;
    blink_on_d  = blink_on_q;
    over_d      = over_q;
    win_d       = win_q;
    sel_mask_c  = pend_q | onehot(cursor_q);

    // Publish uses pre-update state so a same-cycle mark shows one frame later
    if (frame_start) begin
      cell_d = pend_q;
      curm_d = (state_q == ST_PLAY) ? (onehot(cursor_q) & {CELLS{blink_on_q}}) : '0;
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d = '0;
        blink_on_d  = ~blink_on_q;
      end else begin
        blink_cnt_d = blink_cnt_q + CNT_W'(1);
      end
    end

    case (state_q)
      ST_PLAY, ST_DONE: begin
        if (act_c == ACT_CLR) begin
          state_d  = ST_CLEAR;
          pend_d   = '0;
          win_d    = 1'b0;
          over_d   = 1'b0;
          cursor_d = CURSOR_HOME;
        end else if (state_q == ST_PLAY) begin
          if (act_c == ACT_SEL) begin
            if (!pend_q[cursor_q]) begin
              pend_d = sel_mask_c;
              if (has_line(sel_mask_c)) begin
                state_d = ST_DONE;
                over_d  = 1'b1;
                win_d   = 1'b1;
              end else if (&sel_mask_c) begin
                state_d = ST_DONE;
                over_d  = 1'b1;
                win_d   = 1'b0;
              end
            end
          end else if (act_c != ACT_NONE) begin
            cursor_d = move_cursor(cursor_q, act_c);
          end
        end
      end
      ST_CLEAR: begin
        if (frame_start) state_d = ST_PLAY;
      end
      default: state_d = ST_PLAY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_PLAY;
      pend_q      <= '0;
      cell_q      <= '0;
      curm_q      <= '0;
      cursor_q    <= CURSOR_HOME;
      blink_cnt_q <= '0;
      blink_on_q  <= 1'b1;
      over_q      <= 1'b0;
      win_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      cell_q      <= cell_d;
      curm_q      <= curm_d;
      cursor_q    <= cursor_d;
      blink_cnt_q <= blink_cnt_d;
      blink_on_q  <= blink_on_d;
      over_q      <= over_d;
      win_q       <= win_d;
    end
  end

  assign cell_mask   = cell_q;
  assign cursor_mask = curm_q;
  assign cursor_idx  = cursor_q;
  assign game_over   = over_q;
  assign win         = win_q;

endmodule

// File: tb/tb_cell_select_ctrl.sv
// Randomized self-checking bench for cell_select_ctrl against a row/column game model.
module tb_cell_select_ctrl;

  localparam int BF = 1;
  localparam logic [5:0] B_CLR = 6'b100000, B_SEL = 6'b010000, B_UP = 6'b001000,
                         B_DOWN = 6'b000100, B_LEFT = 6'b000010, B_RIGHT = 6'b000001;
  localparam int S_PLAY = 0, S_DONE = 1, S_CLEAR = 2;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
  logic btn_sel = 1'b0, btn_clr = 1'b0, frame_start = 1'b0;
  logic [8:0] cell_mask, cursor_mask;
  logic [3:0] cursor_idx;
  logic game_over, win;

  int tests = 0;
  int fails = 0;

  // Model: board as 9 flags, cursor as row/col, published copies, frame counter
  bit       m_marks[9];
  int       m_row, m_col, m_state, m_frames;
  bit       m_win;
  logic [8:0] m_cell, m_curm;
  logic [5:0] m_prev;

  cell_select_ctrl #(.BLINK_FRAMES(BF)) dut (
    .clk(clk), .reset(reset), .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left),
    .btn_right(btn_right), .btn_sel(btn_sel), .btn_clr(btn_clr), .frame_start(frame_start),
    .cell_mask(cell_mask), .cursor_mask(cursor_mask), .cursor_idx(cursor_idx),
    .game_over(game_over), .win(win)
  );

  always #5 clk = ~clk;

  function automatic logic [8:0] marks_vec();
    logic [8:0] v;
    for (int i = 0; i < 9; i++) v[i] = m_marks[i];
    return v;
  endfunction

  function automatic bit any_line();
    bit hit;
    hit = 0;
    for (int k = 0; k < 3; k++) begin
      if (m_marks[3*k] && m_marks[3*k+1] && m_marks[3*k+2]) hit = 1;
      if (m_marks[k] && m_marks[k+3] && m_marks[k+6]) hit = 1;
    end
    if (m_marks[0] && m_marks[4] && m_marks[8]) hit = 1;
    if (m_marks[2] && m_marks[4] && m_marks[6]) hit = 1;
    return hit;
  endfunction

  function automatic logic [23:0] exp_vec();
    return {m_cell, m_curm, 4'(m_row * 3 + m_col), m_state == S_DONE, m_win};
  endfunction

  function automatic logic [23:0] act_vec();
    return {cell_mask, cursor_mask, cursor_idx, game_over, win};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 9; i++) m_marks[i] = 0;
    m_row = 1; m_col = 1; m_state = S_PLAY; m_frames = 0; m_win = 0;
    m_cell = '0; m_curm = '0; m_prev = '0;
  endtask

  task automatic model_step(input logic [5:0] lv, input bit fs);
    logic [5:0] ev;
    int idx, old;
    ev = lv & ~m_prev;
    m_prev = lv;
    old = m_state;
    idx = m_row * 3 + m_col;
    if (fs) begin
      m_cell = marks_vec();
      m_curm = (old == S_PLAY && ((m_frames / BF) % 2 == 0)) ? (9'(1) << idx) : 9'h000;
      m_frames++;
    end
    if (old == S_CLEAR) begin
      if (fs) m_state = S_PLAY;
    end else if (ev[5]) begin
      for (int i = 0; i < 9; i++) m_marks[i] = 0;
      m_row = 1; m_col = 1; m_win = 0; m_state = S_CLEAR;
    end else if (old == S_PLAY) begin
      if (ev[4]) begin
        if (!m_marks[idx]) begin
          m_marks[idx] = 1;
          if (any_line()) begin m_state = S_DONE; m_win = 1; end
          else if (marks_vec() == 9'h1FF) begin m_state = S_DONE; m_win = 0; end
        end
      end
      else if (ev[3]) m_row = (m_row + 2) % 3;
      else if (ev[2]) m_row = (m_row + 1) % 3;
      else if (ev[1]) m_col = (m_col + 2) % 3;
      else if (ev[0]) m_col = (m_col + 1) % 3;
    end
  endtask

  task automatic step(input logic [5:0] lv, input bit fs);
    @(negedge clk);
    {btn_clr, btn_sel, btn_up, btn_down, btn_left, btn_right} = lv;
    frame_start = fs;
    @(posedge clk);
    #1;
    model_step(lv, fs);
  endtask

  task automatic press(input logic [5:0] b);
    step(b, 0);
    step(6'b0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    {btn_clr, btn_sel, btn_up, btn_down, btn_left, btn_right} = 6'b0;
    frame_start = 1'b0;
    @(posedge clk);
    #1;
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic goto_cell(input int target);
    for (int k = 0; k < 6 && (m_row * 3 + m_col) != target; k++) begin
      if (m_row != target / 3) press(B_DOWN);
      else press(B_RIGHT);
    end
  endtask

  task automatic test_reset();
    do_reset();
    tests++;
    if (act_vec() !== {9'h000, 9'h000, 4'd4, 1'b0, 1'b0}) begin
      fails++; $display("FAIL reset_state got=%h exp=%h", act_vec(), {9'h000, 9'h000, 4'd4, 2'b00});
    end
    for (int f = 0; f < 3; f++) begin
      step(6'b0, 1);
      tests++;
      if (cursor_mask !== ((f % 2 == 0) ? 9'h010 : 9'h000) || cell_mask !== 9'h000 || cursor_idx !== 4'd4) begin
        fails++; $display("FAIL blink_frame%0d got=%h exp_curm=%h", f, act_vec(), (f % 2 == 0) ? 9'h010 : 9'h000);
      end
    end
  endtask

  task automatic test_moves();
    logic [3:0] exp_idx [4] = '{4'd2, 4'd8, 4'd2, 4'd0};
    logic [5:0] seq [4] = '{B_LEFT, B_UP, B_DOWN, B_RIGHT};
    do_reset();
    press(B_UP);
    press(B_LEFT);
    tests++;
    if (cursor_idx !== 4'd0) begin fails++; $display("FAIL move_to_0 got=%0d exp=0", cursor_idx); end
    for (int i = 0; i < 4; i++) begin
      press(seq[i]);
      tests++;
      if (cursor_idx !== exp_idx[i] || act_vec() !== exp_vec()) begin
        fails++; $display("FAIL move_wrap%0d got=%0d exp=%0d", i, cursor_idx, exp_idx[i]);
      end
    end
    for (int c = 0; c < 50; c++) step(B_UP, 0);
    step(6'b0, 0);
    tests++;
    if (cursor_idx !== 4'd6) begin fails++; $display("FAIL hold_one_move got=%0d exp=6", cursor_idx); end
  endtask

  task automatic test_sel_frame();
    do_reset();
    step(B_SEL, 1);
    tests++;
    if (cell_mask !== 9'h000) begin fails++; $display("FAIL sel_same_frame got=%h exp=000", cell_mask); end
    step(6'b0, 0);
    step(6'b0, 1);
    tests++;
    if (cell_mask !== 9'h010) begin fails++; $display("FAIL sel_next_frame got=%h exp=010", cell_mask); end
    press(B_SEL);
    step(6'b0, 1);
    tests++;
    if (cell_mask !== 9'h010 || game_over !== 1'b0 || act_vec() !== exp_vec()) begin
      fails++; $display("FAIL resel_ignored got=%h exp=%h", act_vec(), exp_vec());
    end
  endtask

  task automatic test_win();
    do_reset();
    goto_cell(0); press(B_SEL);
    goto_cell(1); press(B_SEL);
    goto_cell(2); press(B_SEL);
    tests++;
    if (game_over !== 1'b1 || win !== 1'b1) begin
      fails++; $display("FAIL line_win got=%b%b exp=11", game_over, win);
    end
    press(B_LEFT); press(B_UP); press(B_SEL);
    step(6'b0, 1);
    tests++;
    if (cursor_idx !== 4'd2 || cursor_mask !== 9'h000 || cell_mask !== 9'h007 || act_vec() !== exp_vec()) begin
      fails++; $display("FAIL done_frozen got=%h exp=%h", act_vec(), exp_vec());
    end
    press(B_CLR);
    tests++;
    if (cursor_idx !== 4'd4 || game_over !== 1'b0 || win !== 1'b0) begin
      fails++; $display("FAIL clr_enter got=%h exp idx=4 over=0 win=0", act_vec());
    end
    press(B_LEFT);
    step(6'b0, 1);
    tests++;
    if (cell_mask !== 9'h000 || cursor_mask !== 9'h000 || cursor_idx !== 4'd4) begin
      fails++; $display("FAIL clear_publish got=%h exp=%h", act_vec(), exp_vec());
    end
    press(B_LEFT);
    tests++;
    if (cursor_idx !== 4'd3) begin fails++; $display("FAIL back_to_play got=%0d exp=3", cursor_idx); end
  endtask

  task automatic test_fill();
    int order [9] = '{0, 1, 5, 3, 4, 2, 6, 7, 8};
    do_reset();
    for (int i = 0; i < 9 && m_state == S_PLAY; i++) begin
      goto_cell(order[i]);
      press(B_SEL);
      tests++;
      if (act_vec() !== exp_vec()) begin
        fails++; $display("FAIL fill_step%0d got=%h exp=%h", i, act_vec(), exp_vec());
      end
    end
    tests++;
    if (game_over !== 1'b1 || win !== m_win) begin
      fails++; $display("FAIL fill_end got=%b%b exp=1%b", game_over, win, m_win);
    end
  endtask

  task automatic test_same_cycle_and_reset();
    do_reset();
    step(B_SEL | B_LEFT, 0);
    step(6'b0, 1);
    tests++;
    if (cell_mask !== 9'h010 || cursor_idx !== 4'd4) begin
      fails++; $display("FAIL sel_beats_left got=%h/%0d exp=010/4", cell_mask, cursor_idx);
    end
    press(B_LEFT); press(B_SEL);
    do_reset();
    tests++;
    if (act_vec() !== {9'h000, 9'h000, 4'd4, 1'b0, 1'b0}) begin
      fails++; $display("FAIL midgame_reset got=%h exp=%h", act_vec(), {9'h000, 9'h000, 4'd4, 2'b00});
    end
    step(6'b0, 1);
    tests++;
    if (cell_mask !== 9'h000 || cursor_mask !== 9'h010) begin
      fails++; $display("FAIL reset_no_pending got=%h/%h exp=000/010", cell_mask, cursor_mask);
    end
  endtask

  task automatic test_random();
    logic [5:0] lv;
    bit fs;
    do_reset();
    lv = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < 6; b++) begin
        if ($urandom_range(0, (b == 5) ? 60 : 5) == 0) lv[b] = ~lv[b];
      end
      fs = ($urandom_range(0, 6) == 0);
      step(lv, fs);
      tests++;
      if (act_vec() !== exp_vec()) begin
        fails++; $display("FAIL random_cycle%0d got=%h exp=%h", c, act_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_moves();
    test_sel_frame();
    test_win();
    test_fill();
    test_same_cycle_and_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
